prbs8_checker: RTL and testbench
================================

# prbs8_checker

Serial receive-side checker for the 8-bit LFSR pattern generator (feedback Q[3]^Q[0], zero-escape term, right shift with new bit in at bit 7). Samples the generator's serial output bit, self-synchronises by loading 8 received bits, then predicts each following bit and counts mismatches. Shows the saturating error count on two active-low seven-segment displays and the lock state on a third. Sits on the board next to the generator, on the same clk, as its loop-back partner.

## Interface
- LOSS_THRESH, 3: consecutive mismatches in LOCKED that force a return to HUNT (range 1..7).
- clk  in  1  system clock; everything changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial bit from the generator (its LIN).
- din_valid  in  1  din is sampled only on cycles where this is 1.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse for each mismatching sampled bit.
- err_cnt  out  8  mismatch count, saturates at 255.
- HEX0  out  7  active-low segments for err_cnt[3:0].
- HEX1  out  7  active-low segments for err_cnt[7:4].
- HEX2  out  7  lock indicator: 7'd127 (blank) in HUNT, 7'd71 ("L") in LOCKED.

## Operation
- State: shift register S[7:0], load counter ld_cnt[2:0], miss counter miss[2:0], err_cnt, and a state machine with two states, HUNT and LOCKED.
- Prediction: pred = (S[3]^S[0]) | (S==0). This is the same function the generator uses.
- Cycles with din_valid=0: all state holds and err_pulse=0.
- HUNT, valid bit:
  - S <= {din, S[7:1]}; ld_cnt increments.
  - No comparison is made.
  - On the 8th bit (ld_cnt==7), go to LOCKED and clear ld_cnt and miss.
- LOCKED, valid bit:
  - Compare din with pred.
  - Match: miss <= 0.
  - Mismatch: err_pulse=1, err_cnt increments unless it is already 255, miss increments.
  - Shift: S <= {pred, S[7:1]} with the macro below defined; S <= {din, S[7:1]} otherwise.
  - If this mismatch makes miss reach LOSS_THRESH: go to HUNT, clear ld_cnt and miss. err_cnt is kept.
- err_cnt is cleared only by rst.
- Reset values: S=0, ld_cnt=0, miss=0, state=HUNT, locked=0, err_pulse=0, err_cnt=0, HEX0=HEX1=7'd64 ("0"), HEX2=7'd127.
- Segment codes, 0..F: 64,121,36,48,25,18,2,120,0,16,8,3,70,33,6,14.

## Timing
- All outputs are registered, or are combinational decodes of registered state only.
- Latency:
  - err_pulse and the err_cnt update appear on the cycle after the edge that sampled the bad bit.
  - HEX0 and HEX1 follow err_cnt in the same cycle.
- Lock: locked rises on the edge that samples the 8th valid bit in HUNT, so it is visible the following cycle.
- The first comparison is made on the 9th valid bit.
- Loss: locked falls on the edge that samples the LOSS_THRESH-th consecutive mismatch. err_pulse=1 in that same cycle.
- rst wins over din_valid on any cycle, including mid-HUNT and mid-LOCKED.
- Saturation: at 255, a further mismatch still pulses err_pulse; err_cnt stays 255.
- din_valid gaps of any length do not affect lock or ld_cnt.

## Configuration
- CHK_FLYWHEEL_EN defined:
  - LOCKED shifts the predicted bit.
  - An isolated bit error counts exactly 1 and does not propagate.
- CHK_FLYWHEEL_EN undefined:
  - LOCKED shifts the received bit.
  - A single bit error also corrupts later predictions (typically 2–3 counted errors).
- HUNT behaviour is identical in both builds.

## Structure
- Shared package prbs8_pkg holds:
  - state enum {HUNT, LOCKED};
  - SEG_BLANK=7'd127, SEG_L=7'd71;
  - the 16-entry hex segment table;
  - the prediction function.
- Sub-module seg7_hex: 4-bit in, 7-bit active-low out, combinational. Instantiated twice, for HEX0 and HEX1.

## Test plan
- Lock:
  - Stimulus: rst, then feed the generator stream from Q=0: 1,0,0,0,0,1,0,0 (ending with S=0x21), then 1.
  - Required: locked=1 after the 8th bit; no err_pulse on the 9th bit; err_cnt=0.
- Single error:
  - Stimulus: after lock, invert one bit of the stream.
  - Required: exactly one err_pulse, one cycle later; err_cnt=1; HEX0=121, HEX1=64. With CHK_FLYWHEEL_EN, no further errors and locked stays 1.
- Loss of lock (LOSS_THRESH=3):
  - Stimulus: after lock, 3 consecutive inverted bits.
  - Required: err_cnt=3; locked=0; HEX2=127. Relocks 8 valid bits later.
- Gaps:
  - Stimulus: drop din_valid for random 1–5 cycle gaps during HUNT and LOCKED.
  - Required: lock occurs on the 8th valid bit; err_cnt=0.
- Saturation:
  - Stimulus: 300 isolated errors, each separated by at least 2 good bits.
  - Required: err_cnt=255; HEX1=HEX0=14; err_pulse still fires on every error.
- Reset mid-operation:
  - Stimulus: assert rst with locked=1 and err_cnt=5.
  - Required: next cycle locked=0, err_cnt=0, HEX0=HEX1=64.

Source files
------------

// File: rtl/prbs8_pkg.sv
// Shared types, segment codes and the LFSR prediction function for the
// PRBS8 loop-back checker.
package prbs8_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam logic [6:0] SEG_BLANK = 7'd127;
    localparam logic [6:0] SEG_L     = 7'd71;

    // Active-low segment patterns for hex digits 0..F.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'd64, 7'd121, 7'd36, 7'd48, 7'd25, 7'd18, 7'd2,  7'd120,
        7'd0,  7'd16,  7'd8,  7'd3,  7'd70, 7'd33, 7'd6,  7'd14
    };

    // Same next-bit function as the generator, including its escape from all-zero.
    function automatic logic prbs8_pred(input logic [7:0] s);
        return (s[3] ^ s[0]) | (s == 8'd0);
    endfunction

endpackage

// File: rtl/seg7_hex.sv
// Combinational hex digit to active-low seven-segment decoder.
module seg7_hex
    import prbs8_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/prbs8_checker.sv
// Self-synchronising PRBS8 receive checker with saturating error count on HEX1/HEX0.
// Optional macro CHK_FLYWHEEL_EN: while locked, shift the predicted bit instead of the received one.
module prbs8_checker
    import prbs8_pkg::*;
#(
    parameter int LOSS_THRESH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    input  logic       din_valid,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2
);

    localparam logic [2:0] THRESH = 3'(LOSS_THRESH);

    chk_state_t state;
    logic [7:0] s;
    logic [2:0] ld_cnt;
    logic [2:0] miss;
    logic       pred;
    logic [2:0] miss_inc;

    assign pred     = prbs8_pred(s);
    assign miss_inc = miss + 3'd1;

    // HUNT loads eight raw bits to seed the predictor; LOCKED compares and counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            s         <= 8'd0;
            ld_cnt    <= 3'd0;
            miss      <= 3'd0;
            err_cnt   <= 8'd0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            if (din_valid) begin
                case (state)
                    HUNT: begin
                        s <= {din, s[7:1]};
                        if (ld_cnt == 3'd7) begin
                            state  <= LOCKED;
                            ld_cnt <= 3'd0;
                            miss   <= 3'd0;
                        end else begin
                            ld_cnt <= ld_cnt + 3'd1;
                        end
                    end
                    LOCKED: begin
`ifdef CHK_FLYWHEEL_EN
                        s <= {pred, s[7:1]};
`else
                        s <= {din, s[7:1]};
`endif
                        if (din == pred) begin
                            miss <= 3'd0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_cnt != 8'hFF)
                                err_cnt <= err_cnt + 8'd1;
                            // A run of misses means the stream slipped; resynchronise from scratch.
                            if (miss_inc == THRESH) begin
                                state  <= HUNT;
                                ld_cnt <= 3'd0;
                                miss   <= 3'd0;
                            end else begin
                                miss <= miss_inc;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);
    assign HEX2   = (state == LOCKED) ? SEG_L : SEG_BLANK;

    seg7_hex u_hex0 (
        .hex (err_cnt[3:0]),
        .seg (HEX0)
    );

    seg7_hex u_hex1 (
        .hex (err_cnt[7:4]),
        .seg (HEX1)
    );

endmodule

// File: tb/tb_prbs8_checker.sv
// Self-checking bench for prbs8_checker: bit-history reference model compared every
// cycle, plus directed hand-computed checkpoints.
module tb_prbs8_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] SEGS [16] = '{
        7'd64, 7'd121, 7'd36, 7'd48, 7'd25, 7'd18, 7'd2,  7'd120,
        7'd0,  7'd16,  7'd8,  7'd3,  7'd70, 7'd33, 7'd6,  7'd14
    };

    always #5 clk = ~clk;

    prbs8_checker #(.LOSS_THRESH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: last eight shifted bits, b[m] = b[m-8] ^ b[m-5], or 1 if all eight are zero.
    bit hist[$];
    bit mLocked = 1'b0;
    bit mPulse = 1'b0;
    bit modelValid = 1'b0;
    int mLoad = 0;
    int mMiss = 0;
    int mErr = 0;

    function automatic bit modelPredict();
        bit anyOne = 1'b0;
        for (int i = 0; i < 8; i++) anyOne |= hist[i];
        return (hist[0] ^ hist[3]) | !anyOne;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            hist = {};
            for (int i = 0; i < 8; i++) hist.push_back(1'b0);
            mLocked = 1'b0;
            mPulse = 1'b0;
            mLoad = 0;
            mMiss = 0;
            mErr = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            mPulse = 1'b0;
            if (din_valid) begin
                if (!mLocked) begin
                    hist.push_back(din);
                    mLoad++;
                    if (mLoad == 8) begin
                        mLocked = 1'b1;
                        mLoad = 0;
                        mMiss = 0;
                    end
                end else begin
                    bit p;
                    p = modelPredict();
`ifdef CHK_FLYWHEEL_EN
                    hist.push_back(p);
`else
                    hist.push_back(din);
`endif
                    if (din == p) begin
                        mMiss = 0;
                    end else begin
                        mPulse = 1'b1;
                        if (mErr < 255) mErr++;
                        mMiss++;
                        if (mMiss == 3) begin
                            mLocked = 1'b0;
                            mLoad = 0;
                            mMiss = 0;
                        end
                    end
                end
                void'(hist.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("locked", locked, mLocked);
            checkOutput("err_pulse", err_pulse, mPulse);
            checkOutput("err_cnt", err_cnt, mErr);
            checkOutput("HEX0", HEX0, SEGS[mErr % 16]);
            checkOutput("HEX1", HEX1, SEGS[mErr / 16]);
            checkOutput("HEX2", HEX2, mLocked ? 7'd71 : 7'd127);
        end
    end

    // Generator on the bench side, started from Q=0 after each reset.
    logic [7:0] gq = 8'd0;

    function automatic logic peekBit(input logic [7:0] q);
        return (q[3] ^ q[0]) | (q == 8'd0);
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic d);
        @(negedge clk);
        rst = r;
        din_valid = v;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        gq = 8'd0;
    endtask

    task automatic sendBit(input logic flip);
        logic b;
        b = peekBit(gq);
        gq = {b, gq[7:1]};
        applyStimulus(1'b0, 1'b1, b ^ flip);
    endtask

    task automatic sendGood(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
    endtask

    task automatic gap();
        int len;
        len = $urandom_range(1, 5);
        for (int i = 0; i < len; i++) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    // Advance until the next one (or two) generator bits are 0, so a flip never makes an all-zero window.
    task automatic waitZeroBits(input int minGood, input bit needTwo);
        int budget;
        sendGood(minGood);
        budget = 300;
        while (budget > 0 && !(peekBit(gq) == 1'b0 &&
               (!needTwo || peekBit({1'b0, gq[7:1]}) == 1'b0))) begin
            sendBit(1'b0);
            budget--;
        end
        if (budget == 0) begin
            errors++;
            $display("[TB] FAIL zero_bit_search: got timeout, expected a 0 bit within 300 bits");
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        int pulses;

        // Reset state
        doReset();
        doReset();
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_err_pulse", err_pulse, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        checkOutput("rst_HEX0", HEX0, 64);
        checkOutput("rst_HEX1", HEX1, 64);
        checkOutput("rst_HEX2", HEX2, 127);

        // Lock on 1,0,0,0,0,1,0,0 then the 9th bit 1 must match
        sendGood(7);
        checkOutput("lock_before_8th", locked, 0);
        sendGood(1);
        checkOutput("lock_after_8th", locked, 1);
        checkOutput("lock_HEX2", HEX2, 71);
        sendBit(1'b0);
        checkOutput("ninth_bit_value", din, 1);
        checkOutput("ninth_no_pulse", err_pulse, 0);
        checkOutput("ninth_err_cnt", err_cnt, 0);

        // Single bit error
        waitZeroBits(10, 1'b0);
        sendBit(1'b1);
        checkOutput("single_pulse", err_pulse, 1);
        checkOutput("single_err_cnt", err_cnt, 1);
        checkOutput("single_HEX0", HEX0, 121);
        checkOutput("single_HEX1", HEX1, 64);
        sendGood(20);
`ifdef CHK_FLYWHEEL_EN
        checkOutput("single_final_cnt", err_cnt, 1);
`else
        checkOutput("single_final_cnt", err_cnt, 3);
`endif
        checkOutput("single_still_locked", locked, 1);

        // Loss of lock: bits 12..14 of the stream are 0,0,0 and get inverted
        doReset();
        sendGood(11);
        sendBit(1'b1);
        checkOutput("loss_first_cnt", err_cnt, 1);
        checkOutput("loss_first_locked", locked, 1);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("loss_pulse", err_pulse, 1);
        checkOutput("loss_err_cnt", err_cnt, 3);
        checkOutput("loss_locked", locked, 0);
        checkOutput("loss_HEX2", HEX2, 127);
        checkOutput("loss_HEX0", HEX0, 48);
        sendGood(7);
        checkOutput("relock_before_8th", locked, 0);
        sendGood(1);
        checkOutput("relock_after_8th", locked, 1);
        waitZeroBits(10, 1'b1);
        checkOutput("relock_clean_cnt", err_cnt, 3);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("mid_err_cnt5", err_cnt, 5);
        checkOutput("mid_locked", locked, 1);

        // Reset mid-LOCKED with err_cnt=5
        doReset();
        checkOutput("midrst_locked", locked, 0);
        checkOutput("midrst_err_cnt", err_cnt, 0);
        checkOutput("midrst_HEX0", HEX0, 64);
        checkOutput("midrst_HEX1", HEX1, 64);

        // Reset mid-HUNT, then lock through random valid gaps
        sendGood(4);
        doReset();
        for (int i = 0; i < 8; i++) begin
            gap();
            sendBit(1'b0);
            if (i == 6) checkOutput("gap_before_8th", locked, 0);
        end
        checkOutput("gap_after_8th", locked, 1);
        for (int i = 0; i < 20; i++) begin
            gap();
            sendBit(1'b0);
        end
        checkOutput("gap_err_cnt", err_cnt, 0);
        checkOutput("gap_locked", locked, 1);

        // Saturation: 300 isolated errors
        doReset();
        sendGood(8);
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            waitZeroBits(12, 1'b0);
            sendBit(1'b1);
            if (err_pulse === 1'b1) pulses++;
        end
        sendGood(12);
        checkOutput("sat_pulses", pulses, 300);
        checkOutput("sat_err_cnt", err_cnt, 255);
        checkOutput("sat_HEX0", HEX0, 14);
        checkOutput("sat_HEX1", HEX1, 14);
        checkOutput("sat_locked", locked, 1);

        applyStimulus(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
